// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: parity codes, serializer states, data width.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = $clog2(DATA_BITS);

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// LSB-first load/shift register with a bit counter; last_o flags the final data bit.
module uart_tx_shift
  import uart_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 bit_out_o,
  output logic                 bit_next_o,
  output logic                 last_o
);

  logic [DATA_BITS-1:0] sr_q;
  logic [CNT_W-1:0]     cnt_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= data_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= {1'b0, sr_q[DATA_BITS-1:1]};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // bit_next_o lets the parent register tx with the bit that follows a shift.
  assign bit_out_o  = sr_q[0];
  assign bit_next_o = sr_q[1];
  assign last_o     = (cnt_q == CNT_W'(DATA_BITS - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Optional feature macro: UART_TX_TWO_STOP_EN adds the per-frame stop_bits input.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int STOP_DEFAULT = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [1:0]           parity_type,
  input  logic                 parity_bit,
`ifdef UART_TX_TWO_STOP_EN
  input  logic                 stop_bits,
`endif
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output tx_state_e            state_dbg_o
);

  tx_state_e  state_q;
  logic       tx_q;
  logic       busy_q;
  logic       done_q;
  logic       stop_cnt_q;
  logic       par_bit_q;
  logic [1:0] par_type_q;
  logic       two_stop;

  logic       load;
  logic       shift;
  logic       bit_out;
  logic       bit_next;
  logic       last;

`ifdef UART_TX_TWO_STOP_EN
  logic two_stop_q;
  assign two_stop = two_stop_q;
`else
  assign two_stop = (STOP_DEFAULT == 2);
`endif

  assign load  = (state_q == S_IDLE) && tx_start;
  assign shift = (state_q == S_DATA) && baud_tick;

  uart_tx_shift u_shift (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .load_i     (load),
    .shift_i    (shift),
    .data_i     (data_in),
    .bit_out_o  (bit_out),
    .bit_next_o (bit_next),
    .last_o     (last)
  );

  // tx is registered, so each transition loads the value of the bit being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stop_cnt_q <= 1'b0;
      par_bit_q  <= 1'b0;
      par_type_q <= PAR_NONE;
`ifdef UART_TX_TWO_STOP_EN
      two_stop_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (tx_start) begin
            par_bit_q  <= parity_bit;
            par_type_q <= parity_type;
`ifdef UART_TX_TWO_STOP_EN
            two_stop_q <= stop_bits;
`endif
            busy_q     <= 1'b1;
            state_q    <= S_PEND;
          end
        end
        S_PEND: begin
          if (baud_tick) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_tick) begin
            state_q <= S_DATA;
            tx_q    <= bit_out;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (!last) begin
              tx_q <= bit_next;
            end else if (parity_enabled(par_type_q)) begin
              state_q <= S_PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q    <= S_STOP;
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            state_q    <= S_STOP;
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (!two_stop || stop_cnt_q) begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              stop_cnt_q <= 1'b0;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx          = tx_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign state_dbg_o = state_q;

endmodule
